alu_issue_seq: RTL

- Instruction sequencer that drives the 8-bit datapath ALU and consumes its result and flags.
- Accepts one instruction per valid/ready handshake and reads operands from a 4-entry register file.
- Drives ALU A/B/select, writes the result back, and latches the Z/N/C/V flags into a status register.
- Evaluates conditional branches against the latched flags.
- Sits between the instruction source and the combinational ALU; it is the ALU's only driver.

---
 rtl/alu_issue_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_issue_seq.sv
// Instruction sequencer for the 8-bit datapath ALU: fetches operands from a
// 4-entry register file, drives the ALU, writes back, latches flags, resolves branches.
module alu_issue_seq #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2,
   parameter int INSTR_W    = 4 + 2*REG_ADDR_W + DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instr,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [3:0]            alu_sel,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic                  alu_z,
   input  logic                  alu_n,
   input  logic                  alu_c,
   input  logic                  alu_v,
   output logic [3:0]            flags,
   output logic                  done,
   output logic                  branch_taken,
   output logic [DATA_W-1:0]     branch_target,
   input  logic [REG_ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0]     dbg_data
);

   localparam int NUM_REGS = 2**REG_ADDR_W;

   localparam logic [3:0] OP_INC = 4'h8;
   localparam logic [3:0] OP_CMP = 4'h9;
   localparam logic [3:0] OP_LDI = 4'hA;
   localparam logic [3:0] OP_BR  = 4'hB;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t                  state;
   logic [DATA_W-1:0]       regs [NUM_REGS];
   logic [3:0]              op_q;
   logic [REG_ADDR_W-1:0]   rd_q;
   logic                    br_pol_q;
   logic [DATA_W-1:0]       imm_q;
   logic                    br_cond;

   logic [3:0]              f_op;
   logic [REG_ADDR_W-1:0]   f_rd;
   logic [REG_ADDR_W-1:0]   f_rs;
   logic [DATA_W-1:0]       f_imm;

   assign f_op  = instr[INSTR_W-1 -: 4];
   assign f_rd  = instr[INSTR_W-5 -: REG_ADDR_W];
   assign f_rs  = instr[DATA_W +: REG_ADDR_W];
   assign f_imm = instr[DATA_W-1:0];

   assign instr_ready = (state == IDLE);
   assign dbg_data    = regs[dbg_sel];

   // Branch condition: rd selects one flag bit, Z first (flags is {Z,N,C,V}).
   always_comb begin
      br_cond = 1'b0;
      case (rd_q[1:0])
         2'd0:    br_cond = flags[3];
         2'd1:    br_cond = flags[2];
         2'd2:    br_cond = flags[1];
         default: br_cond = flags[0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         flags         <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_sel       <= '0;
         done          <= 1'b0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         op_q          <= '0;
         rd_q          <= '0;
         br_pol_q      <= 1'b0;
         imm_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q     <= f_op;
                  rd_q     <= f_rd;
                  br_pol_q <= f_rs[REG_ADDR_W-1];
                  imm_q    <= f_imm;
                  alu_a    <= regs[f_rd];
                  alu_b    <= regs[f_rs];
                  alu_sel  <= (f_op <= OP_CMP) ? f_op : 4'h0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (op_q <= OP_INC) begin
                  regs[rd_q] <= alu_result;
                  flags      <= {alu_z, alu_n, alu_c, alu_v};
               end else if (op_q == OP_CMP) begin
                  flags <= {alu_z, alu_n, alu_c, alu_v};
               end else if (op_q == OP_LDI) begin
                  regs[rd_q] <= imm_q;
               end else if (op_q == OP_BR) begin
                  branch_taken  <= (br_cond == br_pol_q);
                  branch_target <= imm_q;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done          <= 1'b0;
               branch_taken  <= 1'b0;
               branch_target <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
